// File: rtl/fractal_sync_rsp_node_if.sv
// Channel bundle between the two children and the fractal sync responder node.
// Index 0 is the left child and index 1 is the right child.
interface fractal_sync_rsp_node_if #(
  parameter int unsigned AGGR_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned SD_WIDTH   = 2
);
  logic [1:0]                 sync_i;
  logic [1:0][AGGR_WIDTH-1:0] aggr_i;
  logic [1:0][ID_WIDTH-1:0]   id_i;
  logic [1:0][SD_WIDTH-1:0]   src_i;
  logic [1:0]                 wake_o;
  logic [1:0][SD_WIDTH-1:0]   dst_o;
  logic [1:0]                 error_o;

  modport slave (
    input  sync_i, aggr_i, id_i, src_i,
    output wake_o, dst_o, error_o
  );

  modport master (
    output sync_i, aggr_i, id_i, src_i,
    input  wake_o, dst_o, error_o
  );
endinterface

// File: rtl/fractal_sync_rsp_node.sv
// Root responder of the fractal sync tree: pairs left/right sync requests per
// barrier id, wakes both children once complete, and flags protocol errors.
module fractal_sync_rsp_node #(
  parameter int unsigned AGGR_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned SD_WIDTH   = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fractal_sync_rsp_node_if.slave  bus
);

  localparam int unsigned NUM_ENTRIES = 2 ** ID_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ARR0,
    ARR1,
    READY
  } state_e;

  state_e                   state_q [NUM_ENTRIES];
  state_e                   state_d [NUM_ENTRIES];
  logic [1:0][SD_WIDTH-1:0] src_q   [NUM_ENTRIES];
  logic [1:0][SD_WIDTH-1:0] src_d   [NUM_ENTRIES];

  logic [1:0]                wake_q, wake_d;
  logic [1:0][SD_WIDTH-1:0]  dst_q, dst_d;
  logic [1:0]                error_q, error_d;

  logic [1:0]                req_valid;
  logic                      sel_found;
  logic [ID_WIDTH-1:0]       sel_idx;

  // Only requests addressed exactly to this level (aggr == 1) take part in barriers.
  always_comb begin
    req_valid = '0;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = bus.sync_i[p] && (bus.aggr_i[p] == AGGR_WIDTH'(1));
    end
  end

  // Fixed-priority pick of the lowest READY entry, from registered state only.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (!sel_found && state_q[k] == READY) begin
        sel_found = 1'b1;
        sel_idx   = ID_WIDTH'(k);
      end
    end
  end

  always_comb begin
    logic hit0;
    logic hit1;
    hit0    = 1'b0;
    hit1    = 1'b0;
    wake_d  = '0;
    dst_d   = '0;
    error_d = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      state_d[k] = state_q[k];
      src_d[k]   = src_q[k];
    end

    for (int p = 0; p < 2; p++) begin
      if (bus.sync_i[p] && !req_valid[p]) begin
        error_d[p] = 1'b1;
      end
    end

    if (sel_found) begin
      wake_d           = 2'b11;
      dst_d            = src_q[sel_idx];
      state_d[sel_idx] = IDLE;
    end

    // Requests are judged against registered state, so an entry being woken still looks READY.
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      hit0 = req_valid[0] && (bus.id_i[0] == ID_WIDTH'(k));
      hit1 = req_valid[1] && (bus.id_i[1] == ID_WIDTH'(k));
      case (state_q[k])
        IDLE: begin
          if (hit0) src_d[k][0] = bus.src_i[0];
          if (hit1) src_d[k][1] = bus.src_i[1];
          if (hit0 && hit1)  state_d[k] = READY;
          else if (hit0)     state_d[k] = ARR0;
          else if (hit1)     state_d[k] = ARR1;
        end
        ARR0: begin
          if (hit0) error_d[0] = 1'b1;
          if (hit1) begin
            src_d[k][1] = bus.src_i[1];
            state_d[k]  = READY;
          end
        end
        ARR1: begin
          if (hit1) error_d[1] = 1'b1;
          if (hit0) begin
            src_d[k][0] = bus.src_i[0];
            state_d[k]  = READY;
          end
        end
        READY: begin
          if (hit0) error_d[0] = 1'b1;
          if (hit1) error_d[1] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        state_q[k] <= IDLE;
        src_q[k]   <= '0;
      end
      wake_q  <= '0;
      dst_q   <= '0;
      error_q <= '0;
    end else begin
      for (int k = 0; k < NUM_ENTRIES; k++) begin
        state_q[k] <= state_d[k];
        src_q[k]   <= src_d[k];
      end
      wake_q  <= wake_d;
      dst_q   <= dst_d;
      error_q <= error_d;
    end
  end

  assign bus.wake_o  = wake_q;
  assign bus.dst_o   = dst_q;
  assign bus.error_o = error_q;

endmodule

// File: tb/tb_fractal_sync_rsp_node.sv
// Directed-vector bench for fractal_sync_rsp_node: a table of single-cycle
// request patterns with hand-computed outputs, plus a mid-barrier reset sequence.
module tb_fractal_sync_rsp_node;

  logic clk;
  logic rst;

  fractal_sync_rsp_node_if #(.AGGR_WIDTH(2), .ID_WIDTH(2), .SD_WIDTH(2)) bus ();

  fractal_sync_rsp_node #(.AGGR_WIDTH(2), .ID_WIDTH(2), .SD_WIDTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] sync;
    logic [1:0] aggr0;
    logic [1:0] aggr1;
    logic [1:0] id0;
    logic [1:0] id1;
    logic [1:0] src0;
    logic [1:0] src1;
    logic [1:0] exp_wake;
    logic [1:0] exp_dst0;
    logic [1:0] exp_dst1;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vecs[$];
  int   compared;
  int   mismatched;

  function automatic vec_t mk(string n, logic [1:0] sy, logic [1:0] a0, logic [1:0] a1,
                              logic [1:0] i0, logic [1:0] i1, logic [1:0] s0, logic [1:0] s1,
                              logic [1:0] ew, logic [1:0] d0, logic [1:0] d1, logic [1:0] ee);
    vec_t v;
    v.name = n;  v.sync = sy;  v.aggr0 = a0;  v.aggr1 = a1;
    v.id0 = i0;  v.id1 = i1;   v.src0 = s0;   v.src1 = s1;
    v.exp_wake = ew;  v.exp_dst0 = d0;  v.exp_dst1 = d1;  v.exp_err = ee;
    return v;
  endfunction

  // Compare all registered outputs as one observation.
  task automatic checkOutput(input string n, input logic [1:0] ew, input logic [1:0] ed0,
                             input logic [1:0] ed1, input logic [1:0] ee);
    compared++;
    if (bus.wake_o !== ew || bus.dst_o[0] !== ed0 || bus.dst_o[1] !== ed1 || bus.error_o !== ee) begin
      mismatched++;
      $display("[TB] FAIL %s: got wake=%b dst0=%b dst1=%b err=%b, expected wake=%b dst0=%b dst1=%b err=%b",
               n, bus.wake_o, bus.dst_o[0], bus.dst_o[1], bus.error_o, ew, ed0, ed1, ee);
    end
  endtask

  task automatic driveIdle();
    bus.sync_i = '0;
    bus.aggr_i = '0;
    bus.id_i   = '0;
    bus.src_i  = '0;
  endtask

  // Present one cycle of requests, let the edge sample them, then check just after it.
  task automatic applyStimulus(input vec_t v);
    bus.sync_i    = v.sync;
    bus.aggr_i[0] = v.aggr0;
    bus.aggr_i[1] = v.aggr1;
    bus.id_i[0]   = v.id0;
    bus.id_i[1]   = v.id1;
    bus.src_i[0]  = v.src0;
    bus.src_i[1]  = v.src1;
    @(posedge clk);
    #1;
    driveIdle();
    checkOutput(v.name, v.exp_wake, v.exp_dst0, v.exp_dst1, v.exp_err);
  endtask

  localparam logic [1:0] OK = 2'b01;

  initial begin
    compared   = 0;
    mismatched = 0;
    driveIdle();
    rst = 1'b1;

    //            name          sync   a0  a1   id0   id1   src0   src1   wake   dst0   dst1   err
    vecs.push_back(mk("basic_p0",   2'b01, OK, OK, 2'd1, 2'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("basic_gap1", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("basic_gap2", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("basic_p1",   2'b10, OK, OK, 2'd0, 2'd1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("basic_wake", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00));
    vecs.push_back(mk("basic_once", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("repeat_req", 2'b11, OK, OK, 2'd1, 2'd1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("repeat_wk",  2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00));
    vecs.push_back(mk("repeat_end", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("simul_req",  2'b11, OK, OK, 2'd2, 2'd2, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("simul_wake", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00));
    vecs.push_back(mk("dup_first",  2'b01, OK, OK, 2'd0, 2'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("dup_second", 2'b01, OK, OK, 2'd0, 2'd0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("dup_nowake", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("aggr_10",    2'b10, OK, 2'b10, 2'd0, 2'd0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("aggr_00_p1", 2'b10, OK, 2'b00, 2'd0, 2'd0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10));
    vecs.push_back(mk("aggr_00_p0", 2'b01, 2'b00, OK, 2'd3, 2'd0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01));
    vecs.push_back(mk("aggr_quiet", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("dup_finish", 2'b10, OK, OK, 2'd0, 2'd0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("dup_wake",   2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00));
    vecs.push_back(mk("dup_end",    2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("arb_part",   2'b11, OK, OK, 2'd0, 2'd3, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("arb_done",   2'b11, OK, OK, 2'd3, 2'd0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("arb_wake0",  2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk("arb_wake3",  2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00));
    vecs.push_back(mk("arb_end",    2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("reuse_part", 2'b11, OK, OK, 2'd0, 2'd1, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("reuse_done", 2'b11, OK, OK, 2'd1, 2'd0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("reuse_err",  2'b11, OK, OK, 2'd1, 2'd0, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b11));
    vecs.push_back(mk("reuse_wk1",  2'b10, OK, OK, 2'd0, 2'd0, 2'b00, 2'b10, 2'b11, 2'b00, 2'b10, 2'b00));
    vecs.push_back(mk("freed_done", 2'b01, OK, OK, 2'd0, 2'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk("freed_wake", 2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00));
    vecs.push_back(mk("freed_end",  2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Mid-barrier reset: the pending port-0 arrival and the error pulse must vanish.
    applyStimulus(mk("rst_arr0", 2'b01, OK, OK, 2'd1, 2'd0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(mk("rst_errp", 2'b10, OK, 2'b00, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0;
    applyStimulus(mk("post_p1",    2'b10, OK, OK, 2'd0, 2'd1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(mk("post_nowk",  2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(mk("post_p0",    2'b01, OK, OK, 2'd1, 2'd0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    applyStimulus(mk("post_wake",  2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b00));
    applyStimulus(mk("post_end",   2'b00, OK, OK, 2'd0, 2'd0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fractal_sync_rsp_node.md
# fractal_sync_rsp_node

Responder end of the fractal synchronization protocol: a binary-tree root node with two slave-side channels (port 0 = left child, port 1 = right child). It collects `sync` requests from both children per barrier id and, once both have arrived, issues `wake` to both children with `dst` echoing each child's `src`. It flags protocol violations on `error`. It terminates requests whose aggregation level is this node; it never forwards upward.

## Interface
- `AGGR_WIDTH`, default 1: width of `aggr`; bit 0 is this node's level.
- `ID_WIDTH`, default 2: barrier id width; the node holds `2**ID_WIDTH` barrier entries.
- `SD_WIDTH`, default 2: width of `src`/`dst`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `sync_i`  in  [1:0]  per-port synchronization request, one-cycle pulse per request.
- `aggr_i`  in  [1:0][AGGR_WIDTH-1:0]  per-port aggregation mask.
- `id_i`  in  [1:0][ID_WIDTH-1:0]  per-port barrier id.
- `src_i`  in  [1:0][SD_WIDTH-1:0]  per-port request source.
- `wake_o`  out  [1:0]  per-port wake pulse.
- `dst_o`  out  [1:0][SD_WIDTH-1:0]  per-port wake destination; valid only while the matching `wake_o` is high, 0 otherwise.
- `error_o`  out  [1:0]  per-port one-cycle error pulse.

## Operation
- Each barrier entry k has a state (IDLE, ARR0, ARR1, READY) and two stored `src` values, `src_q[k][0]` and `src_q[k][1]`.
- **Valid request** on port p: `sync_i[p]=1` and `aggr_i[p]` equals exactly 1 (bit 0 set, all higher bits 0).
- **Invalid aggr**: `sync_i[p]=1` with any other `aggr_i[p]` value, including 0.
  - `error_o[p]` pulses.
  - No state change.
- **Valid request on p, id k**, by current state of entry k:
  - IDLE: go to ARRp; store `src_i[p]` into `src_q[k][p]`.
  - ARR(other port): go to READY; store `src_i[p]`.
  - ARRp (same port arrives twice): `error_o[p]` pulses; entry k and stored src are unchanged.
  - READY: `error_o[p]` pulses; entry k is unchanged.
- **Simultaneous valid requests, same id k**:
  - Entry in IDLE: go straight to READY; store both srcs.
  - Entry in ARRp: port p gets an error; the other port's arrival completes the entry (READY).
  - Entry in READY: both ports get an error.
- **Simultaneous valid requests, different ids**: each entry is processed independently.
- **Wake arbiter**:
  - Each cycle, select the lowest-index entry in READY, using registered state.
  - Drive `wake_o=2'b11`, `dst_o[0]=src_q[k][0]`, `dst_o[1]=src_q[k][1]`.
  - The selected entry returns to IDLE on the same edge.
  - At most one barrier is woken per cycle. Fixed priority; higher ids wait.
- A new request for an entry that is being woken in the current cycle sees READY and gets an error. The entry is free from the next cycle.
- **Reset** (`rst_i=1`, async): all entries IDLE, all `src_q`=0, `wake_o`=0, `dst_o`=0, `error_o`=0. A reset mid-barrier drops all partial arrivals; no wake is issued for them.

## Timing
- All outputs are registered.
- `error_o[p]` is high exactly in the cycle after the offending request. It can coincide with `wake_o`.
- Wake latency: request completing entry k sampled at edge t. `wake_o` is high in cycle t+1 if no lower-index entry is READY. Otherwise it is delayed by one cycle per lower READY entry ahead of it.
- `wake_o` is a one-cycle pulse per barrier; both bits always assert together.
- No backpressure: requests are accepted every cycle on both ports.
- `dst_o` is 0 in any cycle with `wake_o=0`.

## Test plan
- **Basic barrier**: port0 id=1 src=2'b01 at cycle 0; port1 id=1 src=2'b10 at cycle 3. Expect `wake_o=11`, `dst_o[0]=01`, `dst_o[1]=10` in cycle 4 only. Entry 1 is then IDLE (a repeat round works).
- **Simultaneous arrival**: both ports send id=2 in the same cycle. Expect wake in the next cycle and `error_o=00`.
- **Protocol errors**:
  - port0 sends id=0 twice with no port1 arrival: `error_o=01` after the second request, no wake.
  - port1 sends `aggr=2'b10` (AGGR_WIDTH=2): `error_o=10`, no state change.
  - `aggr=0`: `error_o` pulses, no state change.
- **Arbitration**: complete ids 3 and 0 in the same cycle (port0 id=3 and port1 id=0, with the partners pending). Expect wake for id 0 in cycle t+1 and id 3 in cycle t+2, with the correct `dst` values each time.
- **Reuse while READY**: complete id 1 while id 0 is also READY, so id 1's wake is delayed. Port0 re-requests id 1 before its wake. Expect `error_o[0]`; id 1 is still woken once.
- **Reset mid-operation**: port0 arrives at id 1, assert `rst_i` asynchronously, release, then port1 arrives at id 1. Expect no wake; the entry is ARR1. All outputs are 0 during reset.
